// File: rtl/res_text_renderer_pkg.sv
// Shared types and constants for the resolution-text renderer.
// The ROM row width mirrors the resolution character ROM's line size.
package res_text_renderer_pkg;

  localparam int RESLINE_SIZE   = 136;
  localparam int RT_ROM_LATENCY = 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    ARMED,
    SHIFT
  } rt_state_t;

endpackage

// File: rtl/res_text_renderer_serializer.sv
// Row serializer: holds one ROM row and emits it MSB-first, repeating
// every bit 2^SCALE_SHIFT times while enabled.
module rt_serializer #(
  parameter int LINE_WIDTH  = 136,
  parameter int SCALE_SHIFT = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [LINE_WIDTH-1:0] load_data,
  input  logic                  enable,
  output logic                  msb,
  output logic                  done
);

  localparam int CNT_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [1:0] REP_MAX = 2'((1 << SCALE_SHIFT) - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LINE_WIDTH - 1);

  logic [LINE_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [1:0]            rep_cnt_q, rep_cnt_d;
  logic                  rep_wrap;

  assign rep_wrap = (rep_cnt_q == REP_MAX);
  assign msb      = shift_q[LINE_WIDTH-1];
  assign done     = enable && rep_wrap && (bit_cnt_q == '0);

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    if (load) begin
      shift_d   = load_data;
      bit_cnt_d = CNT_INIT;
      rep_cnt_d = 2'd0;
    end else if (enable) begin
      rep_cnt_d = rep_wrap ? 2'd0 : rep_cnt_q + 2'd1;
      // Advance to the next bit only after its last replica went out.
      if (rep_wrap) begin
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= 2'd0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

endmodule

// File: rtl/res_text_renderer.sv
// Resolution-text renderer: fetches one character-ROM row per video line and
// serializes it, scaled, into a pixel stream at a fixed window position.
module res_text_renderer
  import res_text_renderer_pkg::*;
#(
  parameter int LINE_WIDTH  = RESLINE_SIZE,
  parameter int ROWS        = 16,
  parameter int X_POS       = 16,
  parameter int Y_POS       = 16,
  parameter int SCALE_SHIFT = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  line_start,
  input  logic [11:0]           x,
  input  logic [11:0]           y,
  input  logic                  de,
  output logic [3:0]            rom_addr,
  input  logic [LINE_WIDTH-1:0] rom_q,
  output logic                  pixel_on,
  output logic                  de_out
);

  rt_state_t   state_q, state_d;
  logic [3:0]  rom_addr_q, rom_addr_d;
  logic        pixel_on_q, pixel_on_d;
  logic        de_out_q, de_out_d;

  logic [11:0] ry;
  logic [11:0] ry_row;
  logic        in_window;
  logic        hit;
  logic        ser_load;
  logic        ser_en;
  logic        ser_msb;
  logic        ser_done;

  // The y >= Y_POS term rejects lines whose subtraction wrapped.
  assign ry        = y - 12'(Y_POS);
  assign ry_row    = ry >> SCALE_SHIFT;
  assign in_window = (y >= 12'(Y_POS)) && (ry_row < 12'(ROWS));

  assign hit      = (state_q == ARMED) && de && (x == 12'(X_POS));
  assign ser_load = (state_q == WAIT);
  assign ser_en   = !line_start && (hit || ((state_q == SHIFT) && de));

  rt_serializer #(
    .LINE_WIDTH (LINE_WIDTH),
    .SCALE_SHIFT(SCALE_SHIFT)
  ) u_serializer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (ser_load),
    .load_data(rom_q),
    .enable   (ser_en),
    .msb      (ser_msb),
    .done     (ser_done)
  );

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    pixel_on_d = ser_en && ser_msb;
    de_out_d   = de;
    // A new line always wins, aborting whatever line was in flight.
    if (line_start) begin
      if (in_window) begin
        rom_addr_d = ry_row[3:0];
        state_d    = FETCH;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        FETCH:   state_d = WAIT;
        WAIT:    state_d = ARMED;
        ARMED:   if (hit) state_d = ser_done ? IDLE : SHIFT;
        SHIFT:   if (ser_done) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rom_addr_q <= 4'd0;
      pixel_on_q <= 1'b0;
      de_out_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      pixel_on_q <= pixel_on_d;
      de_out_q   <= de_out_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign pixel_on = pixel_on_q;
  assign de_out   = de_out_q;

endmodule

// File: tb/tb_res_text_renderer.sv
// Scoreboard bench: two renderers (scale 1x and 2x) share stimulus; a
// behavioural per-line model predicts each active pixel.
module tb_res_text_renderer;

  localparam int LW = 136;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          line_start = 1'b0;
  logic [11:0]   x = '0;
  logic [11:0]   y = '0;
  logic          de = 1'b0;
  logic [3:0]    addr_w [2];
  logic [LW-1:0] romq_w [2];
  logic          pix [2];
  logic          deo [2];

  logic [LW-1:0] rom [16];

  int errors = 0;
  int checks = 0;

  bit        lv [2];
  int        lrow [2];
  bit        lhit [2];
  int        lk [2];
  logic [3:0] exp_addr [2];
  bit        eq0 [$];
  bit        eq1 [$];

  always #5 clock = ~clock;

  res_text_renderer #(.SCALE_SHIFT(0)) d0 (
    .clock(clock), .reset_n(reset_n), .line_start(line_start), .x(x), .y(y),
    .de(de), .rom_addr(addr_w[0]), .rom_q(romq_w[0]), .pixel_on(pix[0]),
    .de_out(deo[0])
  );

  res_text_renderer #(.SCALE_SHIFT(1)) d1 (
    .clock(clock), .reset_n(reset_n), .line_start(line_start), .x(x), .y(y),
    .de(de), .rom_addr(addr_w[1]), .rom_q(romq_w[1]), .pixel_on(pix[1]),
    .de_out(deo[1])
  );

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clock) begin
    romq_w[0] <= rom[addr_w[0]];
    romq_w[1] <= rom[addr_w[1]];
  end

  task automatic start_line(input int yv);
    for (int i = 0; i < 2; i++) begin
      lv[i]   = (yv >= 16) && (((yv - 16) >> i) < 16);
      lhit[i] = 1'b0;
      lk[i]   = 0;
      if (lv[i]) begin
        lrow[i]     = (yv - 16) >> i;
        exp_addr[i] = 4'(lrow[i]);
      end
    end
  endtask

  task automatic model_pixel(input int xv);
    logic [LW-1:0] rw;
    bit e;
    for (int i = 0; i < 2; i++) begin
      e = 1'b0;
      if (lv[i]) begin
        if (!lhit[i] && xv == 16) begin
          lhit[i] = 1'b1;
          lk[i]   = 0;
        end
        if (lhit[i] && lk[i] < (LW << i)) begin
          rw = rom[lrow[i]];
          e  = rw[LW - 1 - (lk[i] >> i)];
          lk[i]++;
        end
      end
      if (i == 0) eq0.push_back(e);
      else        eq1.push_back(e);
    end
  endtask

  task automatic cyc(input bit ls, input int yv, input bit dv, input int xv);
    @(negedge clock);
    line_start = ls;
    y  = 12'(yv);
    de = dv;
    x  = 12'(xv);
    if (ls) start_line(yv);
    if (dv) model_pixel(xv);
  endtask

  task automatic check_addr(input int yv);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (addr_w[i] !== exp_addr[i]) begin
        errors++;
        $display("FAIL rom_addr%0d y=%0d: got %0d want %0d", i, yv, addr_w[i], exp_addr[i]);
      end
    end
  endtask

  task automatic run_line(input int yv, input int active_len, input int drop_at,
                          input int drop_len, input int tail, input bit do_ls);
    cyc(do_ls, yv, 1'b0, 0);
    cyc(1'b0, yv, 1'b0, 0);
    check_addr(yv);
    repeat (4) cyc(1'b0, yv, 1'b0, 0);
    for (int a = 0; a < active_len; a++) begin
      if (a == drop_at) repeat (drop_len) cyc(1'b0, yv, 1'b0, a);
      cyc(1'b0, yv, 1'b1, a);
    end
    repeat (tail) cyc(1'b0, yv, 1'b0, 0);
  endtask

  // Monitor: every cycle with de_out consumes one predicted pixel.
  initial begin
    bit e;
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (deo[i]) begin
          if ((i == 0 && eq0.size() == 0) || (i == 1 && eq1.size() == 0)) begin
            errors++;
            $display("FAIL de_out%0d: got 1 want 0 (no pixel expected) t=%0t", i, $time);
          end else begin
            e = (i == 0) ? eq0.pop_front() : eq1.pop_front();
            if (pix[i] !== e) begin
              errors++;
              $display("FAIL pixel_on%0d: got %0b want %0b t=%0t", i, pix[i], e, $time);
            end
          end
        end else if (pix[i] !== 1'b0) begin
          errors++;
          $display("FAIL idle_pixel%0d: got %0b want 0 t=%0t", i, pix[i], $time);
        end
      end
    end
  end

  initial begin
    for (int r = 0; r < 16; r++)
      for (int b = 0; b < LW; b++) rom[r][b] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 2; i++) begin
      lv[i] = 1'b0; lhit[i] = 1'b0; lk[i] = 0; lrow[i] = 0; exp_addr[i] = 4'd0;
    end

    repeat (3) @(negedge clock);
    check_addr(-1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pix[i] !== 1'b0 || deo[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out%0d: got pix=%0b de=%0b want 0 0", i, pix[i], deo[i]);
      end
    end
    reset_n = 1'b1;

    run_line(18, 400, -1, 0, 4, 1'b1);
    for (int yy = 14; yy <= 49; yy++) run_line(yy, 320, -1, 0, 4, 1'b1);
    run_line(20, 400, 100, 5, 4, 1'b1);
    run_line(40, 400, 37, 5, 4, 1'b1);
    // Next line_start lands while both renderers are still shifting.
    run_line(20, 120, -1, 0, 1, 1'b1);
    run_line(33, 400, -1, 0, 4, 1'b1);

    // Asynchronous reset in the middle of a span.
    cyc(1'b1, 22, 1'b0, 0);
    repeat (5) cyc(1'b0, 22, 1'b0, 0);
    for (int a = 0; a < 60; a++) cyc(1'b0, 22, 1'b1, a);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pix[i] !== 1'b0 || deo[i] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset%0d: got pix=%0b de=%0b want 0 0", i, pix[i], deo[i]);
      end
      lv[i] = 1'b0;
      exp_addr[i] = 4'd0;
    end
    de = 1'b0;
    repeat (3) cyc(1'b0, 22, 1'b0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    run_line(22, 300, -1, 0, 4, 1'b0);
    run_line(22, 300, -1, 0, 4, 1'b1);

    for (int n = 0; n < 25; n++) begin
      int yv, al, da, dl;
      yv = int'($urandom_range(10, 55));
      al = int'($urandom_range(150, 400));
      da = int'($urandom_range(0, 300));
      dl = int'($urandom_range(0, 8));
      run_line(yv, al, da, dl, int'($urandom_range(1, 4)), 1'b1);
    end

    repeat (4) @(negedge clock);
    checks++;
    if (eq0.size() != 0 || eq1.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d/%0d pending pixels want 0/0", eq0.size(), eq1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
